// File: rtl/expr_pkg.sv
// Shared constants and types for the expression string generator and its
// matching recognizer.
package expr_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_PLUS = 8'h2B;
  localparam logic [7:0] ASCII_STAR = 8'h2A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    OP    = 2'd2
  } expr_state_t;

  // Plain-vector state codes for the FSM register, kept equal to the enum.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DIGIT = 2'd1;
  localparam logic [1:0] ST_OP    = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  function automatic logic [7:0] op_char(input logic op);
    return (op == OP_MUL) ? ASCII_STAR : ASCII_PLUS;
  endfunction

endpackage

// File: rtl/expr_gen_char_sel.sv
// Combinational character selector: maps (state, idx, operands, operators)
// to the ASCII character to present. Returns 0x00 outside DIGIT/OP.
module expr_char_sel
  import expr_pkg::*;
#(
  parameter int MAX_OPS = 8,
  parameter int LEN_W   = $clog2(MAX_OPS + 1),
  localparam int OPS_W  = (MAX_OPS > 1) ? MAX_OPS - 1 : 1
) (
  input  logic [1:0]           state,
  input  logic [LEN_W-1:0]     idx,
  input  logic [4*MAX_OPS-1:0] digits,
  input  logic [OPS_W-1:0]     ops,
  output logic [7:0]           ch
);

  logic [3:0] digit;
  logic       op;

  // Mux out the operand/operator addressed by idx, then encode as ASCII.
  always_comb begin
    digit = 4'h0;
    op    = OP_ADD;
    for (int i = 0; i < MAX_OPS; i++) begin
      if (idx == LEN_W'(i)) digit = digits[4*i +: 4];
    end
    for (int i = 0; i < OPS_W; i++) begin
      if (idx == LEN_W'(i)) op = ops[i];
    end
    case (state)
      ST_DIGIT: ch = ASCII_ZERO + {4'h0, digit};
      ST_OP:    ch = op_char(op);
      default:  ch = 8'h00;
    endcase
  end

endmodule

// File: rtl/expr_gen.sv
// Expression string generator: serializes a latched batch of BCD operands and
// +/* operators as ASCII over a valid/ready byte stream, grammar
// digit([+*]digit)*. All outputs are registered.
module expr_gen
  import expr_pkg::*;
#(
  parameter int MAX_OPS = 8,
  parameter int LEN_W   = $clog2(MAX_OPS + 1),
  localparam int OPS_W  = (MAX_OPS > 1) ? MAX_OPS - 1 : 1
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic [4*MAX_OPS-1:0] digits,
  input  logic [OPS_W-1:0]     ops,
  output logic [7:0]           ch,
  output logic                 ch_valid,
  input  logic                 ch_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  logic [1:0]           state, state_nxt;
  logic [LEN_W-1:0]     idx, idx_nxt;
  logic [LEN_W-1:0]     len_q;
  logic [4*MAX_OPS-1:0] digits_q, dig_src;
  logic [OPS_W-1:0]     ops_q, ops_src;
  logic                 legal, accept, hs, done_nxt, err_nxt;
  logic [7:0]           ch_nxt;

  assign hs = ch_valid && ch_ready;

  // Request check: length in range and every used operand is a BCD digit.
  always_comb begin
    legal = (len != '0) && (int'(len) <= MAX_OPS);
    for (int i = 0; i < MAX_OPS; i++) begin
      if ((i < int'(len)) && (digits[4*i +: 4] > 4'd9)) legal = 1'b0;
    end
  end

  // Next-state, index and pulse logic.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    accept    = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (legal) begin
            accept    = 1'b1;
            state_nxt = ST_DIGIT;
            idx_nxt   = '0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_DIGIT: begin
        if (hs) begin
          if (idx == len_q - LEN_W'(1)) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_OP;
          end
        end
      end
      ST_OP: begin
        if (hs) begin
          idx_nxt   = idx + LEN_W'(1);
          state_nxt = ST_DIGIT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The first character is computed from the live inputs on the accept edge,
  // since the latches only become visible one cycle later.
  assign dig_src = accept ? digits : digits_q;
  assign ops_src = accept ? ops    : ops_q;

  expr_char_sel #(
    .MAX_OPS (MAX_OPS),
    .LEN_W   (LEN_W)
  ) u_char_sel (
    .state  (state_nxt),
    .idx    (idx_nxt),
    .digits (dig_src),
    .ops    (ops_src),
    .ch     (ch_nxt)
  );

  // State, latches and registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= ST_IDLE;
      idx      <= '0;
      len_q    <= '0;
      digits_q <= '0;
      ops_q    <= '0;
      ch       <= 8'h00;
      ch_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      if (accept) begin
        len_q    <= len;
        digits_q <= digits;
        ops_q    <= ops;
      end
      ch       <= ch_nxt;
      ch_valid <= (state_nxt != ST_IDLE);
      busy     <= (state_nxt != ST_IDLE);
      done     <= done_nxt;
      err      <= err_nxt;
    end
  end

endmodule

// File: doc/expr_gen.md
# expr_gen

Expression string generator: the transmit-side counterpart of the digit/operator string recognizer. It takes a batch of BCD operands and operator codes and serializes them as 8-bit ASCII characters. Output follows the grammar digit([+*]digit)*, so every string it emits drives the recognizer's `out` high at its end. It sits between a test or stimulus controller and any byte-serial consumer, using a valid/ready handshake.

## Interface
- `MAX_OPS`, default 8: maximum number of operands per string; must be ≥1.
- `LEN_W`, default $clog2(MAX_OPS+1): width of `len`.
- `clk`  in  1  clock. All state updates on rising edge.
- `clr`  in  1  reset: asynchronous, active-high.
- `start`  in  1  request pulse. Sampled only in IDLE.
- `len`  in  LEN_W  number of operands, legal range 1..MAX_OPS.
- `digits`  in  4*MAX_OPS  BCD operands. Operand i is `digits[4i+3:4i]`; operand 0 is sent first.
- `ops`  in  MAX_OPS-1 (min 1)  operator bits. Bit i sits between operand i and operand i+1: 0 = '+' (0x2B), 1 = '*' (0x2A).
- `ch`  out  8  current ASCII character.
- `ch_valid`  out  1  `ch` is valid.
- `ch_ready`  in  1  consumer accepts `ch` this cycle.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse when a transfer completes.
- `err`  out  1  one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, DIGIT, OP.
- **IDLE**
  - A `start` with a legal request latches `len`, `digits` and `ops` into internal registers, clears the operand index `idx`, and moves to DIGIT.
  - A request is illegal if `len`==0, `len`>MAX_OPS, or any operand with index < `len` is >9. An illegal `start` pulses `err`, stays in IDLE, and emits nothing.
- **DIGIT**
  - `ch` = 0x30 + operand[`idx`].
  - On handshake, if `idx`==`len`-1: pulse `done` and go to IDLE. Otherwise go to OP.
- **OP**
  - `ch` = operator char for `ops[idx]`.
  - On handshake: `idx`++, go to DIGIT.
- **Handshake rules**
  - Handshake = `ch_valid && ch_ready`.
  - While `ch_valid`=1 and `ch_ready`=0, `ch` holds stable.
  - `ch_valid` never drops without a handshake, except on reset.
- Total characters per transfer = 2·`len`−1.
- `start` while `busy` is ignored: no `err`, and latched data is unchanged.
- Live `digits`/`ops` inputs may change freely after acceptance, because only the latched copies are used.
- `ch_valid`=1 exactly in DIGIT/OP. `busy` = (state ≠ IDLE).
- When `ch_valid`=0, `ch` = 0x00.

## Timing
- **Reset:** `clr` forces IDLE, `idx`=0, `ch`=0x00, `ch_valid`=0, `busy`=0, `done`=0, `err`=0, immediately and asynchronously. Reset mid-transfer abandons the string with no `done`. The first legal `start` after `clr` deasserts behaves normally.
- **Start latency:** `start` sampled at edge N → `ch_valid`=1 and `busy`=1 after edge N. The first digit is visible in cycle N+1.
- **Throughput:** with `ch_ready` held high, one character per cycle, with no bubbles between DIGIT and OP.
- **Completion:** final handshake at edge M → `done`=1, `busy`=0, `ch_valid`=0 in cycle M+1. `done` is high for exactly one cycle.
- **Back-to-back:** a new `start` may be accepted in the same cycle `done` is high, because the FSM is already in IDLE.
- **Rejection:** `err` is high in the cycle after the illegal `start` edge, for one cycle.
- All outputs are registered.

## Structure
- Package `expr_pkg` holds:
  - `ASCII_ZERO` (8'h30), `ASCII_PLUS` (8'h2B), `ASCII_STAR` (8'h2A);
  - state enum `expr_state_t` {IDLE, DIGIT, OP};
  - operator codes `OP_ADD`=0, `OP_MUL`=1.
- The recognizer and this block share the ASCII constants from the package.
- One combinational sub-module is natural: `expr_char_sel`. It takes state, `idx`, and the latched operands/operators, and returns the next `ch`. The parent holds the FSM, `idx` counter, latches and handshake.

## Test plan
- Reset, then `len`=1, digit0=7, `ch_ready`=1 → `ch`=0x37 for one cycle, then `done` pulse next cycle; `busy` high for exactly 1 cycle.
- `len`=3, digits=4,0,9, ops=0,1, `ch_ready`=1 → stream "4+0*9" (0x34,0x2B,0x30,0x2A,0x39) in 5 consecutive cycles, then `done`.
- Same request with `ch_ready` toggling 1,0,0,1,… → `ch` stable during stalls, identical 5-char sequence, no drops or duplicates.
- Illegal requests:
  - `len`=0 → `err` pulse, `ch_valid` stays 0.
  - `len`=2 with digit1=0xA → `err` pulse, `ch_valid` stays 0.
  - Digit5=0xF with `len`=2 → accepted, because only indices < `len` are checked.
- Robustness:
  - `start` asserted mid-transfer with different data → ignored, original string completes.
  - `clr` pulsed after 2 characters → outputs zero at once, no `done`; next legal `start` streams correctly.
- `len`=MAX_OPS=8, all digits 9, ops alternating → 15 chars, last is 0x39, then `done`. Feed the stream to the recognizer and confirm its `out`=1 after the final char.
